// File: rtl/i2s_tx_seq_pkg.sv
// i2s_tx_seq_pkg: shared state encoding and default sizes for the I2S transmit sequencer
package i2s_tx_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;
  localparam int DATA_W_DEF = 24;
  localparam int SLOT_W_DEF = 32;
  localparam int DIV_W_DEF = 8;
  localparam logic [15:0] UNDERFLOW_MAX = 16'hFFFF;
endpackage

// File: rtl/i2s_tx_seq_if.sv
// i2s_tx_seq_if: transmit FIFO read port between the FIFO (slave) and the sequencer (master)
interface i2s_tx_seq_if
  import i2s_tx_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic fifo_empty;
  logic fifo_rd_en;
  logic [2*DATA_W-1:0] fifo_rdata;
  modport master (input fifo_empty, input fifo_rdata, output fifo_rd_en);
  modport slave (output fifo_empty, output fifo_rdata, input fifo_rd_en);
endinterface

// File: rtl/i2s_sclk_gen.sv
// i2s_sclk_gen: programmable sclk divider with a strobe on the cycle before each falling edge
module i2s_sclk_gen
  import i2s_tx_seq_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             aud_mclk,
  input  logic             aud_mrst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             sclk,
  output logic             fall_evt
);
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic sclk_q, sclk_d, tc;
  always_comb begin
    tc = en && (div_cnt_q == div);
    div_cnt_d = (!en || tc) ? '0 : div_cnt_q + 1'b1;
    sclk_d = en && (sclk_q ^ tc);
    fall_evt = tc && sclk_q;
  end
  always_ff @(posedge aud_mclk or negedge aud_mrst_n)
    if (!aud_mrst_n) begin
      div_cnt_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q <= sclk_d;
    end
  assign sclk = sclk_q;
endmodule

// File: rtl/i2s_tx_seq.sv
// i2s_tx_seq: pops one stereo pair per frame and serialises it as standard I2S with underflow tracking
module i2s_tx_seq
  import i2s_tx_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SLOT_W = SLOT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                aud_mclk,
  input  logic                aud_mrst_n,
  input  logic                cfg_en,
  input  logic [DIV_W-1:0]    cfg_sclk_div,
  input  logic                irq_clr,
  i2s_tx_seq_if.master        fifo,
  output logic                sclk_out,
  output logic                lrclk_out,
  output logic                sdata_0_out,
  output logic                irq,
  output logic [15:0]         underflow_cnt,
  output logic                busy
);
  localparam int BC_W = $clog2(2*SLOT_W);
  localparam logic [BC_W-1:0] LAST = BC_W'(2*SLOT_W-1);
  localparam logic [BC_W-1:0] SLOT_B = BC_W'(SLOT_W);
  localparam int PAD = SLOT_W - DATA_W;
  state_e state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2*SLOT_W-1:0] shift_q, shift_d, frame, src_shift;
  logic [SLOT_W-1:0] l_slot, r_slot;
  logic [15:0] ucnt_q, ucnt_d;
  logic delay_q, delay_d, src_delay, lrclk_q, lrclk_d, sdata_q, sdata_d;
  logic rd_en_q, rd_en_d, load_q, load_d, irq_q, irq_d;
  logic idle, fall_evt, wrap, frame_start, underflow;
  i2s_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
    .aud_mclk(aud_mclk),
    .aud_mrst_n(aud_mrst_n),
    .en(busy),
    .div(div_q),
    .sclk(sclk_out),
    .fall_evt(fall_evt)
  );
  always_comb begin
    idle = (state_q == IDLE);
    l_slot = SLOT_W'(fifo.fifo_rdata[2*DATA_W-1:DATA_W]) << PAD;
    r_slot = SLOT_W'(fifo.fifo_rdata[DATA_W-1:0]) << PAD;
    frame = {l_slot, r_slot};
    // A fresh load pre-shifts the MSB into the delay bit so it leaves one sclk after the LRCLK edge
    src_shift = load_q ? frame << 1 : shift_q;
    src_delay = load_q ? frame[2*SLOT_W-1] : delay_q;
    wrap = fall_evt && (bit_cnt_q == LAST);
    frame_start = wrap && (state_q == RUN || cfg_en);
    underflow = frame_start && fifo.fifo_empty;
    rd_en_d = frame_start && !fifo.fifo_empty;
    load_d = rd_en_q;
    state_d = idle ? (cfg_en ? RUN : IDLE) :
              cfg_en ? RUN :
              (state_q == RUN || !wrap) ? STOP : IDLE;
    div_d = (idle && cfg_en) ? cfg_sclk_div : div_q;
    bit_cnt_d = idle ? LAST : !fall_evt ? bit_cnt_q : wrap ? '0 : bit_cnt_q + 1'b1;
    lrclk_d = idle ? 1'b0 : fall_evt ? (bit_cnt_d >= SLOT_B) : lrclk_q;
    sdata_d = idle ? 1'b0 : fall_evt ? src_delay : sdata_q;
    delay_d = (idle || underflow) ? 1'b0 : fall_evt ? src_shift[2*SLOT_W-1] : src_delay;
    shift_d = (idle || underflow) ? '0 : fall_evt ? src_shift << 1 : src_shift;
    irq_d = underflow || (irq_q && !irq_clr);
    ucnt_d = (underflow && ucnt_q != UNDERFLOW_MAX) ? ucnt_q + 16'd1 : ucnt_q;
  end
  always_ff @(posedge aud_mclk or negedge aud_mrst_n)
    if (!aud_mrst_n) begin
      state_q <= IDLE;
      div_q <= '0;
      bit_cnt_q <= LAST;
      shift_q <= '0;
      delay_q <= 1'b0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      rd_en_q <= 1'b0;
      load_q <= 1'b0;
      irq_q <= 1'b0;
      ucnt_q <= '0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      delay_q <= delay_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      rd_en_q <= rd_en_d;
      load_q <= load_d;
      irq_q <= irq_d;
      ucnt_q <= ucnt_d;
    end
  assign busy = !idle;
  assign fifo.fifo_rd_en = rd_en_q;
  assign lrclk_out = lrclk_q;
  assign sdata_0_out = sdata_q;
  assign irq = irq_q;
  assign underflow_cnt = ucnt_q;
endmodule

// File: tb/tb_i2s_tx_seq.sv
// tb_i2s_tx_seq: directed bench for the I2S transmit sequencer at sclk_div=1 (4 mclk per sclk)
module tb_i2s_tx_seq;
  import i2s_tx_seq_pkg::*;
  localparam logic [47:0] DATA = {24'hA55AF0, 24'h0F0F01};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_en = 1'b0;
  logic irq_clr = 1'b0;
  logic [7:0] cfg_sclk_div = 8'd1;
  logic sclk, lrclk, sdata, irq, busy;
  logic [15:0] ucnt;
  int tests = 0, failed = 0, cyc = 0, nfall = 0, nrise = 0, npop = 0, base = 0;
  logic prev_sclk = 1'b0;
  logic rec_sd [0:1023];
  logic rec_lr [0:1023];
  int rec_cyc [0:1023];
  int rec_rise [0:1023];
  int pop_cyc [0:63];
  i2s_tx_seq_if fifo ();
  i2s_tx_seq dut (
    .aud_mclk(clk),
    .aud_mrst_n(rst_n),
    .cfg_en(cfg_en),
    .cfg_sclk_div(cfg_sclk_div),
    .irq_clr(irq_clr),
    .fifo(fifo),
    .sclk_out(sclk),
    .lrclk_out(lrclk),
    .sdata_0_out(sdata),
    .irq(irq),
    .underflow_cnt(ucnt),
    .busy(busy)
  );
  always #5 clk = ~clk;
  // Data is only valid the cycle after a pop; otherwise the FIFO drives all-ones
  always @(posedge clk) fifo.fifo_rdata <= fifo.fifo_rd_en ? DATA : '1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (fifo.fifo_rd_en) begin
      pop_cyc[npop % 64] = cyc;
      npop++;
    end
    if (!prev_sclk && sclk) begin
      rec_rise[nrise % 1024] = cyc;
      nrise++;
    end
    if (prev_sclk && !sclk) begin
      rec_sd[nfall % 1024] = sdata;
      rec_lr[nfall % 1024] = lrclk;
      rec_cyc[nfall % 1024] = cyc;
      nfall++;
    end
    prev_sclk = sclk;
  endtask
  task automatic run_to(input int target);
    for (int i = 0; i < 20000 && nfall < target; i++) step();
    chk("fall_timeout", 64'(nfall >= target), 64'd1);
  endtask
  function automatic logic [23:0] word(input int b);
    logic [23:0] w;
    w = '0;
    for (int i = 0; i < 24; i++) w = {w[22:0], rec_sd[b+i]};
    return w;
  endfunction
  function automatic logic any_one(input int b, input int n);
    logic r;
    r = 1'b0;
    for (int i = 0; i < n; i++) r = r | rec_sd[b+i];
    return r;
  endfunction
  initial begin
    fifo.fifo_empty = 1'b0;
    repeat (3) step();
    chk("rst_outputs", 64'({sclk, lrclk, sdata, irq, busy, fifo.fifo_rd_en}), 64'd0);
    chk("rst_ucnt", 64'(ucnt), 64'd0);
    #2 rst_n = 1'b1;
    repeat (4) step();
    chk("idle_hold", 64'({sclk, lrclk, sdata, busy}), 64'd0);
    cfg_en = 1'b1;
    run_to(130);
    chk("run_busy", 64'(busy), 64'd1);
    chk("sclk_period", 64'(rec_cyc[10] - rec_cyc[9]), 64'd4);
    chk("sclk_high", 64'(rec_cyc[10] - rec_rise[10]), 64'd2);
    chk("lrclk_half", 64'(rec_cyc[32] - rec_cyc[0]), 64'd128);
    chk("lrclk_period", 64'(rec_cyc[64] - rec_cyc[0]), 64'd256);
    chk("pop_count", 64'(npop), 64'd3);
    chk("pop_spacing", 64'(pop_cyc[2] - pop_cyc[1]), 64'd256);
    chk("pop_at_wrap", 64'(pop_cyc[0]), 64'(rec_cyc[0]));
    chk("left_first", 64'(word(1)), 64'h0A55AF0);
    chk("left", 64'(word(65)), 64'h0A55AF0);
    chk("left_pad", 64'(any_one(89, 7)), 64'd0);
    chk("slot_lsb", 64'(rec_sd[96]), 64'd0);
    chk("right", 64'(word(97)), 64'h00F0F01);
    chk("right_pad", 64'(any_one(121, 7)), 64'd0);
    chk("lrclk_edges", 64'({rec_lr[95], rec_lr[96], rec_lr[127], rec_lr[128]}), 64'b0110);
    chk("no_irq", 64'({irq, ucnt}), 64'd0);
    fifo.fifo_empty = 1'b1;
    run_to(194);
    chk("uf_no_pop", 64'(npop), 64'd3);
    chk("uf_cnt1", 64'(ucnt), 64'd1);
    chk("uf_irq", 64'(irq), 64'd1);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("irq_clr", 64'(irq), 64'd0);
    run_to(256);
    repeat (3) step();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    fifo.fifo_empty = 1'b0;
    chk("fall_align", 64'(nfall), 64'd257);
    chk("irq_set_wins", 64'(irq), 64'd1);
    chk("uf_cnt2", 64'(ucnt), 64'd2);
    run_to(331);
    chk("silence", 64'(any_one(192, 128)), 64'd0);
    chk("uf_no_pop2", 64'(npop), 64'd4);
    cfg_en = 1'b0;
    step();
    chk("stop_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 2000 && busy; i++) step();
    chk("stop_at_wrap", 64'(nfall), 64'd385);
    chk("stop_no_pop", 64'(npop), 64'd4);
    chk("stop_no_uf", 64'(ucnt), 64'd2);
    chk("stop_clks_low", 64'({sclk, lrclk}), 64'd0);
    chk("stop_frame_data", 64'(word(353)), 64'h00F0F01);
    repeat (8) step();
    chk("idle_quiet", 64'({sdata, busy, sclk}), 64'd0);
    chk("idle_no_sclk", 64'(nfall), 64'd385);
    base = nfall;
    cfg_en = 1'b1;
    run_to(base + 10);
    cfg_en = 1'b0;
    run_to(base + 20);
    chk("reen_stop_busy", 64'(busy), 64'd1);
    cfg_en = 1'b1;
    run_to(base + 90);
    chk("reen_pop", 64'(npop), 64'd6);
    chk("reen_no_uf", 64'(ucnt), 64'd2);
    chk("reen_gap_a", 64'(rec_cyc[base+64] - rec_cyc[base+63]), 64'd4);
    chk("reen_gap_b", 64'(rec_cyc[base+65] - rec_cyc[base+64]), 64'd4);
    chk("reen_left", 64'(word(base + 65)), 64'h0A55AF0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst", 64'({sclk, lrclk, sdata, irq, busy, fifo.fifo_rd_en}), 64'd0);
    chk("async_rst_ucnt", 64'(ucnt), 64'd0);
    cfg_en = 1'b0;
    #2 rst_n = 1'b1;
    repeat (6) step();
    chk("rst_release_idle", 64'({sclk, lrclk, sdata, irq, busy, fifo.fifo_rd_en}), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
